// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering one of N requesters through an N:1 mux
// into a single registered output stage with a valid/ready handshake
// toward one downstream consumer.
`timescale 1ns/1ps

module rr_mux_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_vld,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_rdy,
    output logic             out_vld,
    output logic [W-1:0]     out_data,
    output logic [IDW-1:0]   out_id,
    input  logic             out_rdy
);

    // Last-granted requester; the search for the next winner starts just after it.
    logic [IDW-1:0] ptr;

    logic           load_en;
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;
    logic [W-1:0]   sel_data;
    logic           take;

    // Output stage can accept a new item when empty or being drained this cycle.
    assign load_en = !out_vld || out_rdy;

    // Rotating priority search: (ptr+1) mod N first, wrapping around, ptr last.
    // The extra index bit keeps ptr+k from overflowing before the modulo-N fold,
    // so non-power-of-two N never visits an unused index code.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N))
                cand = cand - (IDW+1)'(N);
            if (!found && req_vld[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // Data mux and per-requester ready; ready is one-hot on the winner, zero in reset.
    always_comb begin
        sel_data = '0;
        req_rdy  = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDW'(i)) begin
                sel_data   = req_data[i*W +: W];
                req_rdy[i] = !rst && load_en && found;
            end
        end
    end

    assign take = !rst && load_en && found;

    // ---- output register stage: load granted item, or drain to empty ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            ptr      <= IDW'(N-1);
        end else if (take) begin
            out_vld  <= 1'b1;
            out_data <= sel_data;
            out_id   <= winner;
            ptr      <= winner;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N=4 and N=3 builds).
`timescale 1ns/1ps

module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req_vld;
    logic [31:0] req_data;
    logic [3:0]  req_rdy;
    logic        out_vld;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_rdy;

    logic [2:0]  req_vld3;
    logic [23:0] req_data3;
    logic [2:0]  req_rdy3;
    logic        out_vld3;
    logic [7:0]  out_data3;
    logic [1:0]  out_id3;
    logic        out_rdy3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
        .out_vld(out_vld), .out_data(out_data), .out_id(out_id),
        .out_rdy(out_rdy)
    );

    rr_mux_arbiter #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst),
        .req_vld(req_vld3), .req_data(req_data3), .req_rdy(req_rdy3),
        .out_vld(out_vld3), .out_data(out_data3), .out_id(out_id3),
        .out_rdy(out_rdy3)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_vld = 4'b1111; out_rdy = 1'b1;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0000) begin
                failures++; $display("FAIL reset_rdy got=%b exp=%b", req_rdy, 4'b0000);
            end
            @(negedge clk);
            checks++;
            if ({out_vld, out_id, out_data} !== {1'b1 & 1'b0, 2'd0, 8'h00}) begin
                failures++;
                $display("FAIL reset_out got vld=%b id=%0d data=%h exp vld=0 id=0 data=00", out_vld, out_id, out_data);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got=%b exp=%b", req_rdy, 4'b0001);
        end
    endtask

    task automatic test_all_valid();
        logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_d  [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({out_vld, out_id, out_data} !== {1'b1, exp_id[c], exp_d[c]}) begin
                failures++;
                $display("FAIL all_valid[%0d] got vld=%b id=%0d data=%h exp vld=1 id=%0d data=%h",
                         c, out_vld, out_id, out_data, exp_id[c], exp_d[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        req_vld = 4'b0100;
        req_data = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b1, 2'd2, 8'h5C}) begin
            failures++;
            $display("FAIL bp_load got vld=%b id=%0d data=%h exp vld=1 id=2 data=5c", out_vld, out_id, out_data);
        end
        out_rdy = 1'b0; req_vld = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0000) begin
                failures++; $display("FAIL bp_rdy[%0d] got=%b exp=%b", c, req_rdy, 4'b0000);
            end
            @(negedge clk);
            checks++;
            if ({out_vld, out_id, out_data} !== {1'b1, 2'd2, 8'h5C}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got vld=%b id=%0d data=%h exp vld=1 id=2 data=5c", c, out_vld, out_id, out_data);
            end
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b1000) begin
            failures++; $display("FAIL bp_release_rdy got=%b exp=%b", req_rdy, 4'b1000);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b1, 2'd3, 8'hA3}) begin
            failures++;
            $display("FAIL bp_release got vld=%b id=%0d data=%h exp vld=1 id=3 data=a3", out_vld, out_id, out_data);
        end
    endtask

    task automatic test_wrap();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_vld = 4'b0010;
        @(negedge clk);
        req_vld = 4'b0001;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++; $display("FAIL wrap_rdy0 got=%b exp=%b", req_rdy, 4'b0001);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            failures++;
            $display("FAIL wrap_grant0 got vld=%b id=%0d data=%h exp vld=1 id=0 data=a0", out_vld, out_id, out_data);
        end
        req_vld = 4'b1001;
        #1;
        checks++;
        if (req_rdy !== 4'b1000) begin
            failures++; $display("FAIL wrap_rdy3 got=%b exp=%b", req_rdy, 4'b1000);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b1, 2'd3, 8'hA3}) begin
            failures++;
            $display("FAIL wrap_grant3 got vld=%b id=%0d data=%h exp vld=1 id=3 data=a3", out_vld, out_id, out_data);
        end
    endtask

    task automatic test_sparse();
        logic [7:0] d;
        req_vld = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            d = 8'h10 + 8'(c);
            req_data = {8'hA3, 8'hA2, d, 8'hA0};
            #1;
            checks++;
            if (req_rdy !== 4'b0010) begin
                failures++; $display("FAIL sparse_rdy[%0d] got=%b exp=%b", c, req_rdy, 4'b0010);
            end
            @(negedge clk);
            checks++;
            if ({out_vld, out_id, out_data} !== {1'b1, 2'd1, d}) begin
                failures++;
                $display("FAIL sparse_out[%0d] got vld=%b id=%0d data=%h exp vld=1 id=1 data=%h", c, out_vld, out_id, out_data, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_rdy = 1'b0; req_vld = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin
            failures++; $display("FAIL midrst_rdy got=%b exp=%b", req_rdy, 4'b0000);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b0, 2'd0, 8'h00}) begin
            failures++;
            $display("FAIL midrst_out got vld=%b id=%0d data=%h exp vld=0 id=0 data=00", out_vld, out_id, out_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            failures++; $display("FAIL midrst_rdy_after got=%b exp=%b", req_rdy, 4'b0010);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_id, out_data} !== {1'b1, 2'd1, 8'hA1}) begin
            failures++;
            $display("FAIL midrst_grant got vld=%b id=%0d data=%h exp vld=1 id=1 data=a1", out_vld, out_id, out_data);
        end
    endtask

    task automatic test_n3();
        logic [1:0] exp_id [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [7:0] exp_d  [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC0};
        req_vld = 4'b0000; out_rdy = 1'b1;
        req_vld3 = 3'b111; req_data3 = {8'hC2, 8'hC1, 8'hC0}; out_rdy3 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({out_vld3, out_id3, out_data3} !== {1'b1, exp_id[c], exp_d[c]}) begin
                failures++;
                $display("FAIL n3_order[%0d] got vld=%b id=%0d data=%h exp vld=1 id=%0d data=%h",
                         c, out_vld3, out_id3, out_data3, exp_id[c], exp_d[c]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_vld = '0; req_data = '0; out_rdy = 1'b0;
        req_vld3 = '0; req_data3 = '0; out_rdy3 = 1'b0;
        test_reset();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_sparse();
        test_reset_mid();
        test_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
